// File: rtl/mutative_dfp_mem_pkg.sv
// Shared types for the dfp main-memory responder.
//   OFFSET_BITS : byte-offset bits inside one cache line
//   LINE_BITS   : line width on the dfp bus
//   dfp_mem_state_t : responder FSM states
//   dfp_req_t   : request as seen on the bus in the accept cycle
//   addr_pattern: contents returned for a line that was never written
package mutative_types;
  localparam int OFFSET_BITS = 5;
  localparam int LINE_BITS   = 256;
  localparam int WORD_BITS   = 32;
  localparam int LINE_WORDS  = LINE_BITS / WORD_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} dfp_mem_state_t;

  typedef struct packed {
    logic                 rd;
    logic                 wr;
    logic [31:0]          addr;
    logic [LINE_BITS-1:0] wdata;
  } dfp_req_t;

  // Word w of an unwritten line holds its own byte address.
  function automatic logic [LINE_BITS-1:0] addr_pattern(input logic [31:0] line_addr);
    logic [LINE_BITS-1:0] p;
    for (int w = 0; w < LINE_WORDS; w++)
      p[w*WORD_BITS +: WORD_BITS] = line_addr + 32'(4 * w);
    return p;
  endfunction
endpackage

// File: rtl/mutative_dfp_mem_if.sv
// Cache downward-facing port (dfp) bundle.
//   master : cache side, drives addr/read/write/wdata
//   slave  : memory side, drives rdata/resp
interface mutative_dfp_mem_if;
  logic [31:0]                         dfp_addr;
  logic                                dfp_read;
  logic                                dfp_write;
  logic [mutative_types::LINE_BITS-1:0] dfp_wdata;
  logic [mutative_types::LINE_BITS-1:0] dfp_rdata;
  logic                                dfp_resp;

  modport master (output dfp_addr, dfp_read, dfp_write, dfp_wdata,
                  input  dfp_rdata, dfp_resp);
  modport slave  (input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
                  output dfp_rdata, dfp_resp);
endinterface

// File: rtl/mutative_line_store.sv
// Single-port line array with per-line valid bits.
//   clk, rst : clock, async active-high reset (clears valid bits only)
//   en, we   : access enable / write select, one access per cycle
//   idx      : line index
//   wdata    : line to write
//   rdata    : registered read data (holds until next read)
//   rvalid   : registered valid bit of the line last read
module mutative_line_store
  import mutative_types::*;
#(
  parameter int DEPTH_LINES = 1024,
  parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 we,
  input  logic [IDX_W-1:0]     idx,
  input  logic [LINE_BITS-1:0] wdata,
  output logic [LINE_BITS-1:0] rdata,
  output logic                 rvalid
);
  logic [LINE_BITS-1:0]   mem [DEPTH_LINES];
  logic [DEPTH_LINES-1:0] valid;

  // Storage itself is never reset; only the valid bits are.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[idx] <= wdata;
      else    rdata    <= mem[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= '0;
      rvalid <= 1'b0;
    end else if (en) begin
      if (we) valid[idx] <= 1'b1;
      else    rvalid     <= valid[idx];
    end
  end
endmodule

// File: rtl/mutative_dfp_mem.sv
// Main-memory responder for the cache dfp port.
//   clk, rst  : clock, async active-high reset
//   dfp       : dfp bus (slave side); resp pulses one cycle, LAT cycles after accept
//   proto_err : sticky flag for any protocol violation seen
//   rd_count  : completed reads (wraps)
//   wr_count  : completed writes (wraps)
module mutative_dfp_mem
  import mutative_types::*;
#(
  parameter int DEPTH_LINES = 1024,
  parameter int RD_LATENCY  = 8,
  parameter int WR_LATENCY  = 8
) (
  input  logic               clk,
  input  logic               rst,
  mutative_dfp_mem_if.slave  dfp,
  output logic               proto_err,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count
);
  localparam int IDX_W   = $clog2(DEPTH_LINES);
  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  dfp_mem_state_t       state;
  logic [CNT_W-1:0]     cnt;
  dfp_req_t             req_q;    // raw bus values at accept, for mid-flight checks
  logic                 cmd_wr;   // resolved command (write wins)
  logic [IDX_W-1:0]     idx_q;

  logic                 accept, lat_one, busy_mismatch, rd_issue;
  logic                 st_en, st_we;
  logic [IDX_W-1:0]     st_idx, addr_idx;
  logic [LINE_BITS-1:0] st_rdata;
  logic                 st_rvalid;

  always_comb begin
    accept   = (state == IDLE) && (dfp.dfp_read || dfp.dfp_write);
    addr_idx = dfp.dfp_addr[OFFSET_BITS +: IDX_W];
    lat_one  = dfp.dfp_write ? (WR_LATENCY == 1) : (RD_LATENCY == 1);
    busy_mismatch = (dfp.dfp_read  != req_q.rd)  ||
                    (dfp.dfp_write != req_q.wr)  ||
                    (dfp.dfp_addr  != req_q.addr);
    // Reads fetch on the edge entering RESP so data lands with the pulse.
    rd_issue = (accept && lat_one && !dfp.dfp_write) ||
               ((state == BUSY) && (cnt == CNT_W'(1)) && !cmd_wr);
    // Writes commit on the edge leaving RESP; never overlaps a read issue.
    st_we  = (state == RESP) && cmd_wr;
    st_en  = st_we || rd_issue;
    st_idx = (state == IDLE) ? addr_idx : idx_q;
  end

  mutative_line_store #(.DEPTH_LINES(DEPTH_LINES), .IDX_W(IDX_W)) u_store (
    .clk    (clk),
    .rst    (rst),
    .en     (st_en),
    .we     (st_we),
    .idx    (st_idx),
    .wdata  (req_q.wdata),
    .rdata  (st_rdata),
    .rvalid (st_rvalid)
  );

  assign dfp.dfp_resp  = (state == RESP);
  assign dfp.dfp_rdata = ((state == RESP) && !cmd_wr)
                         ? (st_rvalid ? st_rdata
                                      : addr_pattern(32'({idx_q, {OFFSET_BITS{1'b0}}})))
                         : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      cmd_wr    <= 1'b0;
      idx_q     <= '0;
      proto_err <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          req_q  <= '{rd: dfp.dfp_read, wr: dfp.dfp_write,
                      addr: dfp.dfp_addr, wdata: dfp.dfp_wdata};
          cmd_wr <= dfp.dfp_write;
          idx_q  <= addr_idx;
          if ((dfp.dfp_read && dfp.dfp_write) ||
              (dfp.dfp_addr[OFFSET_BITS-1:0] != '0))
            proto_err <= 1'b1;
          if (lat_one) state <= RESP;
          else begin
            state <= BUSY;
            cnt   <= dfp.dfp_write ? CNT_W'(WR_LATENCY - 1) : CNT_W'(RD_LATENCY - 1);
          end
        end
        BUSY: begin
          // Changed or dropped request: keep going with the latched one.
          if (busy_mismatch) proto_err <= 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          if (cmd_wr) wr_count <= wr_count + 16'd1;
          else        rd_count <= rd_count + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mutative_dfp_mem.sv
module tb_mutative_dfp_mem;
  import mutative_types::*;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mutative_dfp_mem_if if0 ();
  mutative_dfp_mem_if if1 ();
  logic        proto0, proto1;
  logic [15:0] rdc0, wrc0, rdc1, wrc1;

  mutative_dfp_mem #(.DEPTH_LINES(DEPTH), .RD_LATENCY(4), .WR_LATENCY(4)) dut0 (
    .clk(clk), .rst(rst), .dfp(if0), .proto_err(proto0), .rd_count(rdc0), .wr_count(wrc0));
  mutative_dfp_mem #(.DEPTH_LINES(DEPTH), .RD_LATENCY(1), .WR_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .dfp(if1), .proto_err(proto1), .rd_count(rdc1), .wr_count(wrc1));

  int n_cmp = 0, n_bad = 0;
  int resp_cyc;

  // Reference model for dut0: written lines by index, transaction counts.
  logic [255:0] m_mem [int];
  int m_rd, m_wr;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [255:0] pat(input int idx);
    logic [255:0] p;
    for (int w = 0; w < 8; w++) p[w*32 +: 32] = 32'(idx * 32 + 4 * w);
    return p;
  endfunction

  function automatic logic [255:0] model_read(input int idx);
    if (m_mem.exists(idx)) return m_mem[idx];
    return pat(idx);
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> OFFSET_BITS) % DEPTH);
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] d;
    for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    m_mem.delete();
    m_rd = 0;
    m_wr = 0;
  endtask

  function automatic logic get_resp(input bit sel);
    return sel ? if1.dfp_resp : if0.dfp_resp;
  endfunction

  function automatic logic [255:0] get_rdata(input bit sel);
    return sel ? if1.dfp_rdata : if0.dfp_rdata;
  endfunction

  task automatic drv(input bit sel, input bit rd, input bit wr,
                     input logic [31:0] a, input logic [255:0] d);
    if (sel) begin
      if1.dfp_read = rd; if1.dfp_write = wr; if1.dfp_addr = a; if1.dfp_wdata = d;
    end else begin
      if0.dfp_read = rd; if0.dfp_write = wr; if0.dfp_addr = a; if0.dfp_wdata = d;
    end
  endtask

  // Counts cycles from the request cycle until resp; -1 on timeout.
  task automatic wait_resp(input bit sel, input int start,
                           output int lat, output logic [255:0] data);
    bit got = 0;
    lat  = start;
    data = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (get_resp(sel)) begin
        got = 1; data = get_rdata(sel); resp_cyc = cyc;
      end else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!got) lat = -1;
  endtask

  // Called and returns at posedge+1; request held until resp, then released.
  task automatic txn(input bit sel, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [255:0] d, input int exp_lat, input string nm);
    int lat;
    logic [255:0] got;
    int idx;
    idx = line_of(a);
    drv(sel, rd, wr, a, d);
    wait_resp(sel, 0, lat, got);
    chk({nm, " latency"}, 256'(lat), 256'(exp_lat));
    if (!wr) chk({nm, " rdata"}, got, model_read(idx));
    if (wr) m_mem[idx] = d;
    if (!sel) begin
      if (wr) m_wr++;
      else    m_rd++;
    end
    @(posedge clk); #1;
    drv(sel, 0, 0, '0, '0);
    if (!wr) chk({nm, " rdata after resp"}, get_rdata(sel), '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv(0, 0, 0, '0, '0);
    drv(1, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit           rd;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    int           exp_lat;
    bit           exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int c0, lat;
    logic [255:0] got, dz, dw;
    bit seen;

    tbl[0] = '{1, 0, 32'h0000_0040, '0,                 4, 0};
    tbl[1] = '{0, 1, 32'h0000_0040, {8{32'hDEADBEEF}},  4, 0};
    tbl[2] = '{1, 0, 32'h0000_0040, '0,                 4, 0};
    tbl[3] = '{0, 1, 32'h0000_8000, {8{32'h1234_5678}}, 4, 0};
    tbl[4] = '{1, 0, 32'h0000_0000, '0,                 4, 0};
    tbl[5] = '{1, 0, 32'h0000_7FE0, '0,                 4, 0};

    // Reset state
    rst = 1'b1;
    drv(0, 0, 0, '0, '0);
    drv(1, 0, 0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset resp",  256'(if0.dfp_resp), '0);
    chk("reset rdata", if0.dfp_rdata, '0);
    chk("reset proto", 256'(proto0), '0);
    chk("reset rd_count", 256'(rdc0), '0);
    chk("reset wr_count", 256'(wrc0), '0);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // Latency-1 instance: single read, then back-to-back reads
    c0 = cyc;
    txn(1, 1, 0, 32'h20, '0, 1, "lat1 rd 0x20");
    chk("lat1 first resp cycle", 256'(resp_cyc - c0), 256'(1));
    txn(1, 1, 0, 32'h40, '0, 1, "lat1 rd 0x40");
    chk("lat1 second resp cycle", 256'(resp_cyc - c0), 256'(3));
    chk("lat1 rd_count", 256'(rdc1), 256'(2));
    chk("lat1 proto", 256'(proto1), '0);

    // Directed table on latency-4 instance, back-to-back
    for (int i = 0; i < 6; i++) begin
      txn(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_lat,
          $sformatf("vec%0d", i));
      chk($sformatf("vec%0d proto", i), 256'(proto0), 256'(tbl[i].exp_err));
    end
    chk("vec rd_count", 256'(rdc0), 256'(m_rd));
    chk("vec wr_count", 256'(wrc0), 256'(m_wr));

    // Randomized traffic over a few lines with aliased high bits
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      bit wr;
      a  = 32'($urandom_range(0, 7) * 32 + ($urandom_range(0, 3) << 15));
      wr = ($urandom_range(0, 1) == 1);
      txn(0, !wr, wr, a, rnd_line(), 4, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    chk("rnd rd_count", 256'(rdc0), 256'(m_rd & 16'hFFFF));
    chk("rnd wr_count", 256'(wrc0), 256'(m_wr & 16'hFFFF));
    chk("rnd proto",    256'(proto0), '0);

    // read+write together: treated as write
    do_reset();
    dw = {8{32'hCAFE_F00D}};
    txn(0, 1, 1, 32'h100, dw, 4, "rdwr");
    chk("rdwr proto", 256'(proto0), 256'(1));
    txn(0, 1, 0, 32'h100, '0, 4, "rdwr readback");
    chk("rdwr wr_count", 256'(wrc0), 256'(1));

    // misaligned read: offset ignored
    do_reset();
    txn(0, 1, 0, 32'h44, '0, 4, "misaligned");
    chk("misaligned proto", 256'(proto0), 256'(1));

    // address changed mid-BUSY: latched line is written
    do_reset();
    dz = {8{32'h0BAD_CAFE}};
    drv(0, 0, 1, 32'h80, dz);
    @(posedge clk); #1;
    drv(0, 0, 1, 32'hC0, dz);
    wait_resp(0, 1, lat, got);
    chk("addr change latency", 256'(lat), 256'(4));
    @(posedge clk); #1;
    drv(0, 0, 0, '0, '0);
    m_mem[line_of(32'h80)] = dz;
    m_wr++;
    chk("addr change proto", 256'(proto0), 256'(1));
    txn(0, 1, 0, 32'h80, '0, 4, "addr change orig");
    txn(0, 1, 0, 32'hC0, '0, 4, "addr change other");

    // request dropped early: still completes
    do_reset();
    drv(0, 1, 0, 32'hA0, '0);
    @(posedge clk); #1;
    drv(0, 0, 0, '0, '0);
    wait_resp(0, 1, lat, got);
    chk("drop latency", 256'(lat), 256'(4));
    chk("drop rdata", got, pat(line_of(32'hA0)));
    @(posedge clk); #1;
    chk("drop proto", 256'(proto0), 256'(1));
    chk("drop rd_count", 256'(rdc0), 256'(1));

    // reset two cycles into a write: no resp, no store
    do_reset();
    drv(0, 0, 1, 32'h60, {8{32'h5555_AAAA}});
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    drv(0, 0, 0, '0, '0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if0.dfp_resp) seen = 1;
      if (k == 2) begin
        @(posedge clk); #1 rst = 1'b0;
      end
    end
    @(posedge clk); #1;
    model_reset();
    chk("rst mid-op resp", 256'(seen), '0);
    chk("rst mid-op rd_count", 256'(rdc0), '0);
    chk("rst mid-op wr_count", 256'(wrc0), '0);
    txn(0, 1, 0, 32'h60, '0, 4, "rst mid-op readback");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
